// File: rtl/voxel_pixel_axis_packer.sv
// voxel_pixel_axis_packer: packs sequential renderer pixel writes into framed AXI-Stream beats through a FWFT FIFO
// Ports: clk, rst_n (async active-low); pix_valid/pix_addr/pix_data non-stallable pixel writes;
// m_axis_tdata/tvalid/tready/tuser/tlast packed output stream (tuser = start of frame, tlast = frame or line end);
// clear_stats zeroes the counters; fifo_level, overflow_count, sync_err_count report status.
module voxel_pixel_axis_packer #(
    parameter int SCREEN_WIDTH  = 480,
    parameter int SCREEN_HEIGHT = 360,
    parameter int PIX_W         = 24,
    parameter int PPB           = 1,
    parameter int FIFO_DEPTH    = 16,
    parameter int TLAST_MODE    = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            pix_valid,
    input  logic [31:0]                     pix_addr,
    input  logic [PIX_W-1:0]                pix_data,
    output logic [PIX_W*PPB-1:0]            m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tuser,
    output logic                            m_axis_tlast,
    input  logic                            clear_stats,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic [31:0]                     overflow_count,
    output logic [31:0]                     sync_err_count
);
    localparam int DW = PIX_W*PPB;
    localparam int EW = DW+2;
    localparam int LW = PPB > 1 ? $clog2(PPB) : 1;
    localparam int CW = SCREEN_WIDTH > 1 ? $clog2(SCREEN_WIDTH) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int VW = $clog2(FIFO_DEPTH+1);
    localparam logic [31:0]   LAST_ADDR = 32'(SCREEN_WIDTH*SCREEN_HEIGHT-1);
    localparam logic [LW-1:0] LANE_MAX  = LW'(PPB-1);
    localparam logic [CW-1:0] COL_MAX   = CW'(SCREEN_WIDTH-1);
    localparam logic [VW-1:0] FULL_LVL  = VW'(FIFO_DEPTH);
    typedef enum logic {WAIT_SOF, RUN} state_t;
    state_t st, nxt;
    logic [31:0] exp_addr;
    logic [LW-1:0] lane, cur_lane;
    logic [CW-1:0] col, cur_col;
    logic [DW-1:0] acc, beat;
    logic usr, first, match, accept, sync_err, beat_done, b_user, b_last, pop, push, ovf;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            st <= WAIT_SOF;
        else
            st <= nxt;
    always_comb begin
        nxt = st;
        if (ovf)
            nxt = WAIT_SOF;
        else if (st == WAIT_SOF)
            nxt = first ? RUN : WAIT_SOF;
        else if (sync_err && !first)
            nxt = WAIT_SOF;
    end
    // Address 0 always restarts at lane 0 / column 0, which covers SOF, resync and frame wrap alike.
    always_comb begin
        first     = pix_valid && pix_addr == '0;
        match     = pix_valid && st == RUN && pix_addr == exp_addr;
        accept    = first || match;
        sync_err  = pix_valid && st == RUN && !match;
        cur_lane  = first ? '0 : lane;
        cur_col   = first ? '0 : col;
        beat      = acc;
        beat[int'(cur_lane)*PIX_W +: PIX_W] = pix_data;
        beat_done = accept && cur_lane == LANE_MAX;
        b_user    = cur_lane == '0 ? first : usr;
        // Line ends always fall on the last lane because the width is a multiple of PPB.
        b_last    = pix_addr == LAST_ADDR || (TLAST_MODE == 1 && cur_col == COL_MAX);
        pop       = m_axis_tvalid && m_axis_tready;
        push      = beat_done && (fifo_level != FULL_LVL || pop);
        ovf       = beat_done && !push;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            exp_addr <= '0;
            lane     <= '0;
            col      <= '0;
            acc      <= '0;
            usr      <= 1'b0;
        end else if (accept && !ovf) begin
            exp_addr <= pix_addr == LAST_ADDR ? '0 : pix_addr + 32'd1;
            lane     <= beat_done ? '0 : cur_lane + 1'b1;
            col      <= cur_col == COL_MAX ? '0 : cur_col + 1'b1;
            acc      <= beat;
            if (cur_lane == '0)
                usr <= first;
        end else if (ovf || sync_err) begin
            exp_addr <= '0;
            lane     <= '0;
            col      <= '0;
        end
    always_ff @(posedge clk)
        if (push)
            mem[wp] <= {b_user, b_last, beat};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp         <= '0;
            rp         <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            fifo_level <= fifo_level + VW'(push) - VW'(pop);
        end
    assign m_axis_tvalid = fifo_level != '0;
    assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = m_axis_tvalid ? mem[rp] : '0;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            overflow_count <= '0;
            sync_err_count <= '0;
        end else begin
            overflow_count <= clear_stats ? '0 : overflow_count + 32'(ovf && overflow_count != '1);
            sync_err_count <= clear_stats ? '0 : sync_err_count + 32'(sync_err && sync_err_count != '1);
        end
endmodule

// File: tb/tb_voxel_pixel_axis_packer.sv
// tb_voxel_pixel_axis_packer: directed checks of the pixel packer in PPB=1/frame-tlast and PPB=4/line-tlast builds
module tb_voxel_pixel_axis_packer;
    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W*H;
    typedef struct {
        logic [31:0] addr;
        logic        a_valid;
        logic        a_user;
        logic        a_last;
        logic [23:0] a_data;
        logic        b_valid;
        logic        b_user;
        logic        b_last;
        logic [95:0] b_data;
    } vec_t;
    vec_t vecs [N];
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_valid = 1'b0;
    logic [31:0] pix_addr = '0;
    logic [23:0] pix_data = '0;
    logic clear_stats = 1'b0;
    logic ready_a = 1'b1;
    logic ready_b = 1'b1;
    logic [23:0] a_tdata;
    logic a_tvalid, a_tuser, a_tlast;
    logic [4:0] a_level;
    logic [31:0] a_ovf, a_serr;
    logic [95:0] b_tdata;
    logic b_tvalid, b_tuser, b_tlast;
    logic [4:0] b_level;
    logic [31:0] b_ovf, b_serr;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    voxel_pixel_axis_packer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .PIX_W(24), .PPB(1),
                              .FIFO_DEPTH(16), .TLAST_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_data(pix_data),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(ready_a),
        .m_axis_tuser(a_tuser), .m_axis_tlast(a_tlast), .clear_stats(clear_stats),
        .fifo_level(a_level), .overflow_count(a_ovf), .sync_err_count(a_serr));
    voxel_pixel_axis_packer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .PIX_W(24), .PPB(4),
                              .FIFO_DEPTH(16), .TLAST_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_addr(pix_addr), .pix_data(pix_data),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(ready_b),
        .m_axis_tuser(b_tuser), .m_axis_tlast(b_tlast), .clear_stats(clear_stats),
        .fifo_level(b_level), .overflow_count(b_ovf), .sync_err_count(b_serr));
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic pix(input logic v, input logic [31:0] a);
        pix_valid = v;
        pix_addr  = a;
        pix_data  = a[23:0];
        @(posedge clk);
        #1;
    endtask
    task automatic run_frame(input string tag);
        for (int k = 0; k < N; k++) begin
            pix(1'b1, vecs[k].addr);
            check($sformatf("%s a_valid[%0d]", tag, k), a_tvalid, vecs[k].a_valid);
            check($sformatf("%s a_data[%0d]", tag, k), a_tdata, vecs[k].a_data);
            check($sformatf("%s a_user[%0d]", tag, k), a_tuser, vecs[k].a_user);
            check($sformatf("%s a_last[%0d]", tag, k), a_tlast, vecs[k].a_last);
            check($sformatf("%s a_level[%0d]", tag, k), a_level, 5'd1);
            check($sformatf("%s b_valid[%0d]", tag, k), b_tvalid, vecs[k].b_valid);
            if (vecs[k].b_valid) begin
                check($sformatf("%s b_data[%0d]", tag, k), b_tdata, vecs[k].b_data);
                check($sformatf("%s b_user[%0d]", tag, k), b_tuser, vecs[k].b_user);
                check($sformatf("%s b_last[%0d]", tag, k), b_tlast, vecs[k].b_last);
            end
        end
        pix(1'b0, 32'd0);
        check({tag, " a_drained"}, a_tvalid, 1'b0);
        check({tag, " b_drained"}, b_tvalid, 1'b0);
    endtask
    initial begin
        int va;
        int vb;
        for (int k = 0; k < N; k++) begin
            vecs[k].addr    = k;
            vecs[k].a_valid = 1'b1;
            vecs[k].a_data  = 24'(k);
            vecs[k].a_user  = k == 0;
            vecs[k].a_last  = k == N-1;
            vecs[k].b_valid = (k % 4) == 3;
            vecs[k].b_user  = k == 3;
            vecs[k].b_last  = (k % 8) == 7;
            vecs[k].b_data  = {24'(k), 24'(k-1), 24'(k-2), 24'(k-3)};
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst a_valid", a_tvalid, 1'b0);
        check("rst a_data", a_tdata, 24'd0);
        check("rst a_user_last", {a_tuser, a_tlast}, 2'b00);
        check("rst a_level", a_level, 5'd0);
        check("rst a_ovf", a_ovf, 32'd0);
        check("rst b_serr", b_serr, 32'd0);
        check("rst b_valid", b_tvalid, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame("frame1");
        check("f1 a_ovf", a_ovf, 32'd0);
        check("f1 a_serr", a_serr, 32'd0);
        check("f1 b_serr", b_serr, 32'd0);
        ready_a = 1'b0;
        for (int k = 0; k < N; k++)
            pix(1'b1, k);
        pix(1'b0, 32'd0);
        check("ovf a_level", a_level, 5'd16);
        check("ovf a_ovf", a_ovf, 32'd1);
        check("ovf a_serr", a_serr, 32'd0);
        ready_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain valid[%0d]", i), a_tvalid, 1'b1);
            check($sformatf("drain data[%0d]", i), a_tdata, 24'(i));
            check($sformatf("drain user[%0d]", i), a_tuser, i == 0);
            check($sformatf("drain last[%0d]", i), a_tlast, 1'b0);
            @(posedge clk);
            #1;
        end
        check("drain a_level", a_level, 5'd0);
        run_frame("after_ovf");
        vb = 0;
        for (int k = 0; k < N; k++) begin
            if (k == 3 || k == 4)
                continue;
            pix(1'b1, k);
            if (b_tvalid)
                vb++;
        end
        pix(1'b0, 32'd0);
        check("sync b_beats", vb, 0);
        check("sync b_serr", b_serr, 32'd1);
        run_frame("after_sync");
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        va = 0;
        vb = 0;
        for (int k = 7; k < N; k++) begin
            pix(1'b1, k);
            if (a_tvalid)
                va++;
            if (b_tvalid)
                vb++;
        end
        pix(1'b0, 32'd0);
        check("late a_beats", va, 0);
        check("late b_beats", vb, 0);
        check("late a_serr", a_serr, 32'd0);
        check("late b_serr", b_serr, 32'd0);
        ready_a = 1'b0;
        for (int k = 0; k < 16; k++)
            pix(1'b1, k);
        clear_stats = 1'b1;
        pix(1'b1, 32'd16);
        clear_stats = 1'b0;
        pix(1'b0, 32'd0);
        check("clr a_level", a_level, 5'd16);
        check("clr a_ovf", a_ovf, 32'd0);
        ready_a = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("clr drained", a_level, 5'd0);
        ready_a = 1'b0;
        for (int k = 0; k < 5; k++)
            pix(1'b1, k);
        pix_valid = 1'b0;
        check("mid a_level", a_level, 5'd5);
        check("mid a_valid", a_tvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async a_valid", a_tvalid, 1'b0);
        check("async a_level", a_level, 5'd0);
        check("async a_data", a_tdata, 24'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready_a = 1'b1;
        va = 0;
        for (int k = 5; k < 10; k++) begin
            pix(1'b1, k);
            if (a_tvalid)
                va++;
        end
        check("post_rst a_beats", va, 0);
        pix(1'b1, 32'd0);
        pix_valid = 1'b0;
        check("post_rst sof valid", a_tvalid, 1'b1);
        check("post_rst sof data", a_tdata, 24'd0);
        check("post_rst sof user", a_tuser, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
